mos6502s_stack_sequencer: RTL and testbench

Multi-byte stack transfer sequencer for the 6502 core. It executes 1-, 2- or 3-byte push/pull sequences (PHA/PLA, JSR/RTS, BRK/IRQ/RTI) on a byte-wide memory port. It forms page-1 stack addresses from the current stack pointer value and drives the stack pointer's inc/dec strobes one byte at a time. It sits between the control FSM, which issues start/op, and the stack pointer register plus memory bus.

---
 rtl/mos6502s_stack_sequencer.sv | 158 +++++++++++++++
 tb/tb_mos6502s_stack_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mos6502s_stack_sequencer.sv
// mos6502s_stack_sequencer: 1/2/3-byte stack push/pull sequencer on a byte-wide bus.
// Optional build macro MOS6502S_STACK_DUMMY_READ_EN: pull ops issue one discarded
// read at {8'h01, sp_in} before the first pulled byte.
// Bus requests and SP strobes are decoded from the current state and the live
// sp_in, so the address tracks the stack pointer as it steps byte by byte.
module mos6502s_stack_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [23:0] push_data,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        busy,
  output logic        done,
  output logic [23:0] pull_data
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned FW = 24;
  localparam logic [DW-1:0] STACK_PAGE = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          pull_q;
  logic          dummy_q;
  logic [1:0]    cnt_q;
  logic [1:0]    idx_q;
  logic [FW-1:0] push_q;

  logic          op_rsvd_c;
  logic          op_pull_c;
  logic          dummy_start_c;
  logic [1:0]    op_cnt_c;
  logic          last_c;
  logic [1:0]    push_sel_c;
  logic [1:0]    pull_sel_c;
  logic [DW-1:0] push_byte_c;

  // Operation decode: op[0] selects pull, op[2:1] encodes byte count minus one
  assign op_rsvd_c = (op[2:1] == 2'b11);
  assign op_pull_c = op[0];
  assign op_cnt_c  = 2'(op[2:1] + 2'd1);

`ifdef MOS6502S_STACK_DUMMY_READ_EN
  assign dummy_start_c = op_pull_c;
`else
  assign dummy_start_c = 1'b0;
`endif

  // Byte ordering: pushes go high field first; PULL16 fills PCL then PCH
  assign last_c     = (idx_q == 2'(cnt_q - 2'd1));
  assign push_sel_c = (cnt_q == 2'd1) ? 2'd0 : 2'(2'd2 - idx_q);
  assign pull_sel_c = (cnt_q == 2'd2) ? 2'(idx_q + 2'd1) : idx_q;

  // Select the outgoing push byte for the current index
  always_comb begin
    push_byte_c = push_q[7:0];
    case (push_sel_c)
      2'd2:    push_byte_c = push_q[23:16];
      2'd1:    push_byte_c = push_q[15:8];
      default: push_byte_c = push_q[7:0];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Sequence context, byte index and pulled-byte assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      pull_q    <= 1'b0;
      dummy_q   <= 1'b0;
      cnt_q     <= 2'd0;
      idx_q     <= 2'd0;
      push_q    <= '0;
      pull_data <= '0;
    end else if (state_q == IDLE && start && !op_rsvd_c) begin
      pull_q  <= op_pull_c;
      dummy_q <= dummy_start_c;
      cnt_q   <= op_cnt_c;
      idx_q   <= 2'd0;
      push_q  <= push_data;
    end else if (state_q == XFER && mem_ready) begin
      if (dummy_q) begin
        dummy_q <= 1'b0;
      end else begin
        idx_q <= 2'(idx_q + 2'd1);
        if (pull_q) begin
          case (pull_sel_c)
            2'd2:    pull_data[23:16] <= mem_rdata;
            2'd1:    pull_data[15:8]  <= mem_rdata;
            default: pull_data[7:0]   <= mem_rdata;
          endcase
        end
      end
    end
  end

  // Next-state and bus/strobe decode
  always_comb begin
    state_d   = state_q;
    mem_addr  = AW'(0);
    mem_wdata = DW'(0);
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = op_rsvd_c ? FIN : XFER;
      end
      XFER: begin
        busy = 1'b1;
        if (pull_q) begin
          mem_re = 1'b1;
          if (dummy_q) begin
            mem_addr = {STACK_PAGE, sp_in};
          end else begin
            mem_addr = {STACK_PAGE, 8'(sp_in + 8'd1)};
            sp_inc   = mem_ready;
          end
        end else begin
          mem_we    = 1'b1;
          mem_addr  = {STACK_PAGE, sp_in};
          mem_wdata = push_byte_c;
          sp_dec    = mem_ready;
        end
        if (mem_ready && !dummy_q && last_c) state_d = FIN;
      end
      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mos6502s_stack_sequencer.sv
// Directed bench for mos6502s_stack_sequencer with a stack pointer model and stack memory.
module tb_mos6502s_stack_sequencer;

`ifdef MOS6502S_STACK_DUMMY_READ_EN
  localparam int DR = 1;
`else
  localparam int DR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [23:0] push_data;
  logic [7:0]  sp = 8'h00;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re, sp_inc, sp_dec, busy, done;
  logic [23:0] pull_data;

  logic [7:0]  mem [256];
  logic        sp_ld = 1'b0;
  logic [7:0]  sp_ld_val = 8'h00;
  int          stall_n = 0;
  int          wait_cnt = 0;

  int total = 0, bad = 0;
  int wr_cnt = 0, rd_cnt = 0, inc_cnt = 0, dec_cnt = 0, done_cnt = 0;
  int both_err = 0, stall_err = 0;
  logic [15:0] wr_addr [64];
  logic [7:0]  wr_dat  [64];
  logic [15:0] rd_addr [64];
  logic        prev_req = 1'b0, prev_rdy = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [7:0]  prev_wd = 8'h0;

  always #5 clk = ~clk;

  mos6502s_stack_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .push_data(push_data),
    .sp_in(sp), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .busy(busy), .done(done), .pull_data(pull_data)
  );

  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ready = (wait_cnt >= stall_n);

  // Stack pointer register model
  always @(posedge clk) begin
    if (sp_ld)       sp <= sp_ld_val;
    else if (sp_dec) sp <= sp - 8'd1;
    else if (sp_inc) sp <= sp + 8'd1;
  end

  // Wait-state generator: stall_n not-ready cycles per access
  always @(posedge clk) begin
    if ((mem_we || mem_re) && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                                  wait_cnt <= 0;
  end

  // Bus transaction logger
  always @(posedge clk) begin
    if (mem_we && mem_ready) begin
      wr_addr[wr_cnt[5:0]] <= mem_addr;
      wr_dat[wr_cnt[5:0]]  <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_re && mem_ready) begin
      rd_addr[rd_cnt[5:0]] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (sp_inc) inc_cnt <= inc_cnt + 1;
    if (sp_dec) dec_cnt <= dec_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (sp_inc && sp_dec) both_err <= both_err + 1;
  end

  // Address/data stability across stalled cycles
  always @(negedge clk) begin
    if (prev_req && !prev_rdy && (mem_we || mem_re) &&
        (mem_addr !== prev_addr || mem_wdata !== prev_wd))
      stall_err <= stall_err + 1;
    prev_req  <= mem_we || mem_re;
    prev_rdy  <= mem_ready;
    prev_addr <= mem_addr;
    prev_wd   <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_sp(input logic [7:0] v);
    @(negedge clk);
    sp_ld = 1'b1;
    sp_ld_val = v;
    @(negedge clk);
    sp_ld = 1'b0;
  endtask

  // Issue one op and count negedges until done; 999 means it never completed
  task automatic run(input logic [2:0] o, input logic [23:0] d, output int lat);
    @(negedge clk);
    start = 1'b1;
    op = o;
    push_data = d;
    lat = 999;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
  endtask

  int lat, w0, r0, i0, d0, dn0;
  int spins;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12;
    mem[8'hF1] = 8'h11; mem[8'hF2] = 8'h22; mem[8'hF3] = 8'h33;
    mem[8'hFE] = 8'h9C;
    rst = 1'b1; start = 1'b0; op = 3'd0; push_data = 24'h0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {26'd0, busy, done, mem_we, mem_re, sp_inc, sp_dec}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'h0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'h0);
    check("rst_pull", {8'd0, pull_data}, 32'h0);
    rst = 1'b0;

    // PUSH8 at FD, no stalls
    set_sp(8'hFD);
    w0 = wr_cnt; d0 = dec_cnt;
    run(3'd0, 24'h00005A, lat);
    check("push8_lat", lat, 2);
    check("push8_nwr", wr_cnt - w0, 1);
    check("push8_wr", {8'd0, wr_addr[w0], wr_dat[w0]}, 32'h01FD5A);
    check("push8_dec", dec_cnt - d0, 1);
    check("push8_sp", {24'd0, sp}, 32'hFC);

    // PUSH24 with two wait states per byte
    set_sp(8'hFD);
    stall_n = 2;
    w0 = wr_cnt; d0 = dec_cnt;
    run(3'd4, 24'h1234A5, lat);
    check("push24_lat", lat, 10);
    check("push24_wr0", {8'd0, wr_addr[w0], wr_dat[w0]}, 32'h01FD12);
    check("push24_wr1", {8'd0, wr_addr[w0+1], wr_dat[w0+1]}, 32'h01FC34);
    check("push24_wr2", {8'd0, wr_addr[w0+2], wr_dat[w0+2]}, 32'h01FBA5);
    check("push24_dec", dec_cnt - d0, 3);
    check("push24_stable", stall_err, 0);

    // Reset in the stalled second byte of PUSH16
    set_sp(8'hFD);
    w0 = wr_cnt; d0 = dec_cnt;
    @(negedge clk);
    start = 1'b1; op = 3'd2; push_data = 24'hABCD00;
    @(negedge clk);
    start = 1'b0;
    spins = 0;
    while (wr_cnt == w0 && spins < 50) begin
      @(negedge clk);
      spins++;
    end
    check("abort_reach", {31'd0, spins < 50}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ctl", {26'd0, busy, done, mem_we, mem_re, sp_inc, sp_dec}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_nwr", wr_cnt - w0, 1);
    check("abort_wr", {8'd0, wr_addr[w0], wr_dat[w0]}, 32'h01FDAB);
    check("abort_dec", dec_cnt - d0, 1);
    stall_n = 0;
    w0 = wr_cnt;
    run(3'd0, 24'h000077, lat);
    check("post_lat", lat, 2);
    check("post_wr", {8'd0, wr_addr[w0], wr_dat[w0]}, 32'h01FC77);

    // PULL16 across the FF->00 wrap
    set_sp(8'hFE);
    r0 = rd_cnt; i0 = inc_cnt;
    run(3'd3, 24'h0, lat);
    check("pull16_lat", lat, 3 + DR);
    check("pull16_rd0", {16'd0, rd_addr[r0+DR]}, 32'h01FF);
    check("pull16_rd1", {16'd0, rd_addr[r0+DR+1]}, 32'h0100);
    check("pull16_data", {8'd0, pull_data}, 32'h123400);
    check("pull16_inc", inc_cnt - i0, 2);

    // PULL24 with a stray start mid-sequence
    set_sp(8'hF0);
    stall_n = 1;
    r0 = rd_cnt; dn0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = 3'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; push_data = 24'hFFFFFF;
    @(negedge clk);
    start = 1'b0;
    spins = 0;
    while (!done && spins < 50) begin
      @(negedge clk);
      spins++;
    end
    repeat (4) @(negedge clk);
    check("pull24_done", done_cnt - dn0, 1);
    check("pull24_nrd", rd_cnt - r0, 3 + DR);
    check("pull24_data", {8'd0, pull_data}, 32'h332211);
    check("pull24_sp", {24'd0, sp}, 32'hF3);
    check("pull24_idle", {31'd0, busy}, 32'd0);
    stall_n = 0;

    // Reserved op: no bus activity
    w0 = wr_cnt; r0 = rd_cnt; i0 = inc_cnt; d0 = dec_cnt;
    run(3'd7, 24'h0, lat);
    check("rsvd_lat", lat, 1);
    check("rsvd_bus", (wr_cnt - w0) + (rd_cnt - r0) + (inc_cnt - i0) + (dec_cnt - d0), 0);

    // PULL8 at FD keeps upper fields
    set_sp(8'hFD);
    r0 = rd_cnt; i0 = inc_cnt;
    run(3'd1, 24'h0, lat);
    check("pull8_lat", lat, 2 + DR);
    check("pull8_nrd", rd_cnt - r0, 1 + DR);
`ifdef MOS6502S_STACK_DUMMY_READ_EN
    check("pull8_dummy", {16'd0, rd_addr[r0]}, 32'h01FD);
`endif
    check("pull8_rd", {16'd0, rd_addr[r0+DR]}, 32'h01FE);
    check("pull8_inc", inc_cnt - i0, 1);
    check("pull8_data", {8'd0, pull_data}, 32'h33229C);

    check("no_both_strobe", both_err, 0);
    check("stall_stable", stall_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
